dram_bridge: RTL and testbench
==============================

// Module: dram_bridge
// PURPOSE
//  Sits directly downstream of the mem stage. Turns its single-cycle RAM request (ram_addr/ram_data/ram_w_request/ram_ce)
//  into a multi-cycle req/ack data-bus transaction, and stalls the pipeline until the transaction completes.
//  Every access first reads the addressed word and returns it to the mem stage as ram_data.
//  Stores then write back the merged word the mem stage computes from that read data (read-modify-write for SB/SH).
// PARAMETERS
//  ADDR_WIDTH      32   byte-address width (matches `ADDR_WIDTH)
//  DATA_WIDTH      32   data word width (matches `DATA_WIDTH)
//  TIMEOUT_CYCLES  255  ack watchdog limit; used only with DRAM_BRIDGE_TIMEOUT_EN
// PORTS
//  clk_i         in   1           clock
//  rst_i         in   1           synchronous reset, active-low
//  ram_ce_i      in   1           access request from mem stage (its ram_ce_o)
//  ram_we_i      in   1           store flag from mem stage (its ram_w_request_o)
//  ram_addr_i    in   ADDR_WIDTH  byte address from mem stage
//  ram_wdata_i   in   DATA_WIDTH  merged store word from mem stage (its ram_data_o)
//  ram_rdata_o   out  DATA_WIDTH  read word to mem stage (its ram_data_i)
//  stall_o       out  1           holds IF..MEM pipeline registers while 1
//  bus_req_o     out  1           bus request, held until bus_ack_i
//  bus_we_o      out  1           1 = write beat, 0 = read beat
//  bus_addr_o    out  ADDR_WIDTH  word-aligned address {addr[AW-1:2],2'b00}
//  bus_wdata_o   out  DATA_WIDTH  write data
//  bus_ack_i     in   1           beat complete; bus_rdata_i valid same cycle on reads
//  bus_rdata_i   in   DATA_WIDTH  read data
//  bus_err_o     out  1           sticky timeout flag (0 when feature compiled out)
// BEHAVIOUR
//  Reset (rst_i==0 at posedge): state=IDLE; addr_q, we_q, rdata_q = 0; bus_req_o=0, bus_we_o=0, bus_err_o=0.
//   Reset applies mid-transaction too: req drops the next cycle and the in-flight access is abandoned.
//  FSM states: IDLE, RD, WR, DONE. All bus outputs decode from registered state/addr_q/we_q only.
//  IDLE: if ram_ce_i, latch addr_q=ram_addr_i and we_q=ram_we_i, then go to RD. bus_ack_i is ignored in IDLE.
//  RD: bus_req_o=1, bus_we_o=0. On bus_ack_i: rdata_q<=bus_rdata_i, then go to WR if we_q, else DONE.
//  WR: bus_req_o=1, bus_we_o=1. bus_wdata_o=ram_wdata_i, passed through combinationally.
//   The mem stage is stalled, so this value is stable and already merged with rdata_q.
//   On bus_ack_i, go to DONE.
//  DONE: the only state in which stall is released. Returns to IDLE unconditionally.
//  stall_o = ram_ce_i && (state != DONE). It is combinational, so stall is 1 in the request cycle itself.
//  ram_rdata_o = rdata_q at all times. It updates only on read acks and holds across stalls.
//  Latency with ack on first req cycle: load = 3 cycles (IDLE, RD, DONE); store = 4 cycles (IDLE, RD, WR, DONE).
//   Each wait cycle before ack adds one cycle.
//  Back-to-back accesses: after DONE, the new mem-stage op is sampled in IDLE. There is no bubble beyond IDLE.
//  bus_req_o never rises in IDLE or DONE. bus_we_o=1 only in WR.
//  Addresses with addr[1:0]!=0 go out word-aligned. Byte lane selection remains the mem stage's job.
//  ram_ce_i falling while in RD/WR (flush) does not abort: the beat completes, then the FSM passes through DONE.
// CONFIGURATION
//  DRAM_BRIDGE_TIMEOUT_EN defined:
//   - 8..16-bit wait counter, cleared on entering RD/WR, increments each cycle without ack.
//   - Reaching TIMEOUT_CYCLES: drop req, set bus_err_o=1 (sticky until reset), go to DONE.
//   - A read that times out leaves rdata_q unchanged.
//  DRAM_BRIDGE_TIMEOUT_EN undefined: no counter; bus_err_o tied 0; the FSM waits forever for ack.
// TESTING
//  T1 load: ce=1, we=0, addr=0x104, ack after 2 waits with rdata=0xDEADBEEF ->
//     bus_addr=0x104, req high 3 cycles with we=0, ram_rdata_o=0xDEADBEEF, stall high 4 cycles then low 1 cycle.
//  T2 SB addr=0x203: mem stage merges byte 0x5A into read word 0x11223344, immediate acks ->
//     read beat at 0x200, then write beat with wdata=0x5A223344, stall high 3 cycles.
//  T3 back-to-back LW 0x10 then SW 0x14, zero-wait acks -> exactly 3 + 4 cycles.
//     No req in IDLE/DONE; second read beat is to 0x14.
//  T4 rst_i=0 during WR with req high -> next cycle req=0, state IDLE, rdata_q=0, stall_o=ce.
//  T5 ack pulse while IDLE with ce=0 -> no state change, rdata_q unchanged.
//  T6 (TIMEOUT_EN, TIMEOUT_CYCLES=4) read with no ack -> req drops after 4 cycles, bus_err_o=1 and stays 1,
//     stall released via DONE.

Source files
------------

// File: rtl/dram_bridge_if.sv
// Data-bus side of the DRAM bridge: req/ack beats, one word per beat.
interface dram_bridge_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  req;
  logic                  we;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  ack;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  err;

  modport master (output req, we, addr, wdata, err, input ack, rdata);
  modport slave  (input req, we, addr, wdata, err, output ack, rdata);
endinterface

// File: rtl/dram_bridge.sv
// Converts the mem stage's single-cycle RAM request into a read (and, for stores, a write) bus beat.
// Optional ack watchdog: define DRAM_BRIDGE_TIMEOUT_EN.
module dram_bridge #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  ram_ce_i,
    input  logic                  ram_we_i,
    input  logic [ADDR_WIDTH-1:0] ram_addr_i,
    input  logic [DATA_WIDTH-1:0] ram_wdata_i,
    output logic [DATA_WIDTH-1:0] ram_rdata_o,
    output logic                  stall_o,
    dram_bridge_if.master         bus
);

    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-3:0]   addr_q;
    logic                    we_q;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic                    tmo;
    logic [1:0]              unused_addr_lsb;

    // Byte lanes are the mem stage's concern; the bus only sees word addresses.
    assign unused_addr_lsb = ram_addr_i[1:0];

`ifdef DRAM_BRIDGE_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 255) ? 16 : 8;

    logic [CNT_W-1:0] cnt_q;
    logic             err_q;

    assign tmo = (state_q inside {RD, WR}) && !bus.ack &&
                 (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    // Counter restarts on every state change, so RD and WR each get a full window.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= (state_d != state_q) ? '0 : cnt_q + CNT_W'(1);
            if (tmo) err_q <= 1'b1;
        end
    end

    assign bus.err = err_q;
`else
    logic unused_tmo;

    assign unused_tmo = (TIMEOUT_CYCLES != 0);
    assign tmo        = 1'b0;
    assign bus.err    = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (ram_ce_i) state_d = RD;
            RD: begin
                if (bus.ack)  state_d = we_q ? WR : DONE;
                else if (tmo) state_d = DONE;
            end
            WR:      if (bus.ack || tmo) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            addr_q  <= '0;
            we_q    <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && ram_ce_i) begin
                addr_q <= ram_addr_i[ADDR_WIDTH-1:2];
                we_q   <= ram_we_i;
            end
            if (state_q == RD && bus.ack) rdata_q <= bus.rdata;
        end
    end

    // The mem stage is frozen during WR, so its merged word can pass straight through.
    assign bus.req     = (state_q == RD) || (state_q == WR);
    assign bus.we      = (state_q == WR);
    assign bus.addr    = {addr_q, 2'b00};
    assign bus.wdata   = ram_wdata_i;
    assign ram_rdata_o = rdata_q;
    assign stall_o     = ram_ce_i && (state_q != DONE);

endmodule

// File: tb/tb_dram_bridge.sv
// Randomized bench for dram_bridge: per-cycle expectations from a transaction-timeline model.
module tb_dram_bridge;
    localparam int TMO = 4;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        ce = 1'b0, we = 1'b0;
    logic [31:0] addr = '0, wdata = '0;
    logic [31:0] rdata_o;
    logic        stall;

    dram_bridge_if bus ();

    dram_bridge #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .ram_ce_i   (ce),
        .ram_we_i   (we),
        .ram_addr_i (addr),
        .ram_wdata_i(wdata),
        .ram_rdata_o(rdata_o),
        .stall_o    (stall),
        .bus        (bus)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        bit          req, we, stall, err, clr, chk_addr, chk_wdata;
        logic [31:0] addr, wdata, rdata;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        ce_e;
    int          n_chk = 0, n_fail = 0;
    int          stall_cnt = 0, req_cnt = 0, cyc_cnt = 0;
    logic [31:0] first_raddr = '0, last_raddr = '0, last_wdata = '0;
    bit          seen_req = 0;
    logic [31:0] mem[logic [31:0]];
    logic [31:0] mdl_rdata = '0;
    bit          mdl_err = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chkb(string name, logic act, logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit rbit();
        return 1'($urandom & 1);
    endfunction

    function automatic logic [31:0] rd_mem(logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return (a * 32'h9E3779B1) ^ 32'hA5A50F0F;
    endfunction

    function automatic exp_t mk(bit rq, bit w, bit st, logic [31:0] rd);
        exp_t e;
        e.req = rq; e.we = w; e.stall = st; e.rdata = rd; e.err = mdl_err;
        e.clr = 0; e.chk_addr = 0; e.chk_wdata = 0; e.addr = '0; e.wdata = '0;
        return e;
    endfunction

    // Compare process: one expectation per cycle, sampled mid-cycle.
    initial forever begin
        @(negedge clk_i);
        if (exp_q.size() > 0) begin
            ce_e = exp_q.pop_front();
            if (ce_e.clr) begin
                stall_cnt = 0; req_cnt = 0; cyc_cnt = 0; seen_req = 0;
            end
            chkb("req", bus.req, ce_e.req);
            chkb("we", bus.we, ce_e.we);
            chkb("stall", stall, ce_e.stall);
            chkb("err", bus.err, ce_e.err);
            chk("rdata", rdata_o, ce_e.rdata);
            if (ce_e.chk_addr)  chk("addr", bus.addr, ce_e.addr);
            if (ce_e.chk_wdata) chk("wdata", bus.wdata, ce_e.wdata);
            cyc_cnt++;
            if (stall === 1'b1) stall_cnt++;
            if (bus.req === 1'b1) begin
                req_cnt++;
                if (!seen_req) first_raddr = bus.addr;
                seen_req = 1;
                if (bus.we === 1'b1) last_wdata = bus.wdata;
                else                 last_raddr = bus.addr;
            end
        end
    end

    task automatic cyc(bit ce_v, bit we_v, logic [31:0] a_v, logic [31:0] wd_v,
                       bit ack_v, logic [31:0] rd_v, bit rst_v, exp_t e);
        @(posedge clk_i);
        #1;
        rst_i = rst_v; ce = ce_v; we = we_v; addr = a_v; wdata = wd_v;
        bus.ack = ack_v; bus.rdata = rd_v;
        exp_q.push_back(e);
    endtask

    task automatic idle_cyc(int n);
        exp_t e;
        repeat (n) begin
            e = mk(0, 0, 0, mdl_rdata);
            cyc(0, rbit(), $urandom, $urandom, rbit(), $urandom, 1, e);
        end
    endtask

    // One mem-stage access laid out as a timeline: IDLE, read beat, optional write beat, DONE.
    task automatic run_op(bit we_v, logic [31:0] a, bit sb, logic [7:0] bv, logic [31:0] full,
                          int w1, int w2, bit flush, int rst_at, bit tmo, bit clr);
        logic [31:0] wa, rv, wd, old;
        exp_t e;
        bit cev;
        wa  = {a[31:2], 2'b00};
        old = mdl_rdata;
        rv  = rd_mem(wa);
        wd  = full;
        if (sb) begin
            wd = rv;
            wd[a[1:0]*8 +: 8] = bv;
        end
        e = mk(0, 0, 1, old);
        e.clr = clr;
        cyc(1, we_v, a, wd, rbit(), $urandom, 1, e);
        if (tmo) begin
            for (int j = 0; j < TMO; j++) begin
                e = mk(1, 0, 1, old); e.chk_addr = 1; e.addr = wa;
                cyc(1, we_v, a, wd, 0, $urandom, 1, e);
            end
            mdl_err = 1;
            e = mk(0, 0, 0, old);
            cyc(1, we_v, a, wd, 0, $urandom, 1, e);
            return;
        end
        for (int j = 0; j <= w1; j++) begin
            cev = !(flush && j > 0);
            e = mk(1, 0, cev, old); e.chk_addr = 1; e.addr = wa;
            cyc(cev, we_v, a, wd, j == w1, (j == w1) ? rv : $urandom, 1, e);
        end
        mdl_rdata = rv;
        if (we_v) begin
            for (int j = 0; j <= w2; j++) begin
                cev = !flush;
                e = mk(1, 1, cev, rv);
                e.chk_addr = 1; e.addr = wa; e.chk_wdata = 1; e.wdata = wd;
                if (j == rst_at) begin
                    cyc(cev, we_v, a, wd, 0, $urandom, 0, e);
                    mdl_rdata = '0;
                    mdl_err   = 0;
                    return;
                end
                cyc(cev, we_v, a, wd, j == w2, $urandom, 1, e);
            end
            mem[wa] = wd;
        end
        e = mk(0, 0, 0, mdl_rdata);
        cyc(!flush, we_v, a, wd, 0, $urandom, 1, e);
    endtask

    initial begin
        bus.ack = 1'b0;
        bus.rdata = '0;
        // Reset state, including a request asserted while reset is held.
        cyc(0, 0, 0, 0, 0, 0, 0, mk(0, 0, 0, 0));
        cyc(0, 0, 0, 0, 0, 0, 0, mk(0, 0, 0, 0));
        cyc(1, 0, 0, 0, 0, 0, 0, mk(0, 0, 1, 0));

        // Load with two wait states.
        mem[32'h104] = 32'hDEADBEEF;
        run_op(0, 32'h104, 0, 0, 0, 2, 0, 0, -1, 0, 1);
        @(negedge clk_i); #1;
        chk("t1_stall_cycles", stall_cnt, 4);
        chk("t1_req_cycles", req_cnt, 3);
        chk("t1_rdata", rdata_o, 32'hDEADBEEF);
        chk("t1_addr", first_raddr, 32'h104);

        // Store byte: read-modify-write of lane 3.
        mem[32'h200] = 32'h11223344;
        run_op(1, 32'h203, 1, 8'h5A, 0, 0, 0, 0, -1, 0, 1);
        @(negedge clk_i); #1;
        chk("t2_wdata", last_wdata, 32'h5A223344);
        chk("t2_stall_cycles", stall_cnt, 3);
        chk("t2_raddr", first_raddr, 32'h200);

        // Back-to-back load then store, zero waits.
        run_op(0, 32'h10, 0, 0, 0, 0, 0, 0, -1, 0, 1);
        run_op(1, 32'h14, 0, 0, 32'hCAFEF00D, 0, 0, 0, -1, 0, 0);
        @(negedge clk_i); #1;
        chk("t3_cycles", cyc_cnt, 7);
        chk("t3_raddr0", first_raddr, 32'h10);
        chk("t3_raddr1", last_raddr, 32'h14);
        chk("t3_wdata", last_wdata, 32'hCAFEF00D);

        // Reset in the middle of a write beat.
        run_op(1, 32'h40, 0, 0, 32'h12345678, 0, 2, 0, 1, 0, 1);
        idle_cyc(1);
        @(negedge clk_i); #1;
        chk("t4_rdata", rdata_o, 32'h0);
        chkb("t4_req", bus.req, 1'b0);

        // Stray acks while idle, then a load to show state was untouched.
        idle_cyc(6);
        run_op(0, 32'h8, 0, 0, 0, 1, 0, 0, -1, 0, 1);

        repeat (200) begin
            run_op(rbit(), 32'($urandom_range(0, 63)), rbit(), 8'($urandom), $urandom,
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                   ($urandom_range(0, 7) == 0), -1, 0, 1);
            idle_cyc(int'($urandom_range(0, 2)));
        end

`ifdef DRAM_BRIDGE_TIMEOUT_EN
        run_op(0, 32'h80, 0, 0, 0, 0, 0, 0, -1, 1, 1);
        @(negedge clk_i); #1;
        chkb("t6_err", bus.err, 1'b1);
        chk("t6_req_cycles", req_cnt, TMO);
        chk("t6_stall_cycles", stall_cnt, TMO + 1);
        idle_cyc(3);
`endif

        idle_cyc(1);
        @(negedge clk_i); #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
